// File: rtl/opb_register_simulink2ppc_pkg.sv
// Shared definitions for the Simulink-to-PPC OPB register slave: register
// word indices, STATUS bit positions and the acknowledge FSM state type.
package opb_s2p_pkg;

    // Word indices within the decoded window, after removing the base
    // address and dropping the byte-lane bits.
    localparam logic [29:0] WORD_DATA   = 30'd0;
    localparam logic [29:0] WORD_STATUS = 30'd1;

    // STATUS bit positions in user (little-endian) numbering.
    localparam int STAT_NEW       = 0;
    localparam int STAT_OVERRUN   = 1;
    localparam int STAT_COUNT_LSB = 16;

    // The acknowledge FSM raises the ack once per transfer, then waits for
    // the master to drop select before it accepts another transfer.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_WAIT = 2'd2
    } ackState_t;

    // Builds the STATUS word: update count on top, reserved zeros, then the
    // overrun and new flags.
    function automatic logic [31:0] packStatus(input logic [15:0] count,
                                               input logic        overrun,
                                               input logic        newFlag);
        logic [31:0] w_word;
        w_word                          = '0;
        w_word[STAT_COUNT_LSB +: 16]    = count;
        w_word[STAT_OVERRUN]            = overrun;
        w_word[STAT_NEW]                = newFlag;
        return w_word;
    endfunction

endpackage

// File: rtl/opb_register_simulink2ppc_if.sv
// OPB slave-side bus bundle. Vectors keep the OPB big-endian numbering, so
// OPB bit 0 is the most significant bit of each word.
interface opb_register_simulink2ppc_if;

    logic [0:31] OPB_ABus;
    logic [0:3]  OPB_BE;
    logic [0:31] OPB_DBus;
    logic        OPB_RNW;
    logic        OPB_select;
    logic        OPB_seqAddr;
    logic [0:31] Sl_DBus;
    logic        Sl_xferAck;
    logic        Sl_errAck;
    logic        Sl_retry;
    logic        Sl_toutSup;

    modport master (
        output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
        input  Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
    );

    modport slave (
        input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
        output Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
    );

endinterface

// File: rtl/opb_register_simulink2ppc_ack_fsm.sv
// Address decode and single-pulse transfer acknowledge for the OPB slave.
// o_accept marks the cycle in which a new transfer is taken; the ack follows
// one cycle later and lasts exactly one cycle.
module opb_slave_ack_fsm
    import opb_s2p_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR = 32'h01000F00,
    parameter logic [31:0] C_HIGHADDR = 32'h01000FFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_abus,
    input  logic        i_select,
    output logic        o_accept,
    output logic [29:0] o_word,
    output logic        o_xferAck
);

    ackState_t   r_state;
    logic        r_ack;
    logic        w_hit;
    logic [31:0] w_offset;
    logic [1:0]  w_unusedByteLane;

    assign w_hit            = i_select && (i_abus >= C_BASEADDR) && (i_abus <= C_HIGHADDR);
    assign w_offset         = i_abus - C_BASEADDR;
    assign o_word           = w_offset[31:2];
    assign w_unusedByteLane = w_offset[1:0];
    assign o_accept         = (r_state == ST_IDLE) && w_hit;
    assign o_xferAck        = r_ack;

    // Ack only on the leading edge of a transfer; stay in WAIT until select drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_ack   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_hit) begin
                        r_state <= ST_ACK;
                        r_ack   <= 1'b1;
                    end
                end
                ST_ACK: begin
                    r_state <= ST_WAIT;
                    r_ack   <= 1'b0;
                end
                ST_WAIT: begin
                    if (!i_select) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ack   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/opb_register_simulink2ppc.sv
// OPB slave exposing a user-logic data word (DATA) and its capture status
// (STATUS) to the processor. The ack FSM decodes the bus; this module holds
// the registers, the registered read mux and the flag update rules.
module opb_register_simulink2ppc
    import opb_s2p_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR   = 32'h01000F00,
    parameter logic [31:0] C_HIGHADDR   = 32'h01000FFF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter              C_FAMILY     = "virtex5"
) (
    input  logic                              OPB_Clk,
    input  logic                              OPB_Rst,
    input  logic [31:0]                       user_data_in,
    input  logic                              user_valid,
    opb_register_simulink2ppc_if.slave        bus
);

    logic [31:0] r_data;
    logic [15:0] r_count;
    logic        r_newFlag;
    logic        r_overrun;
    logic [31:0] r_dbus;
    logic        r_clrNewPend;
    logic        r_clrOvrPend;

    logic [31:0] w_abus;
    logic [31:0] w_wdata;
    logic        w_accept;
    logic [29:0] w_word;
    logic        w_xferAck;
    logic        w_clrNew;
    logic        w_clrOvr;
    logic        w_setOvr;
    logic [31:0] w_rdMux;
    logic        w_unusedInputs;

    assign w_abus  = bus.OPB_ABus;
    assign w_wdata = bus.OPB_DBus;

    assign w_unusedInputs = ^{bus.OPB_BE, bus.OPB_seqAddr}
                          ^ ((C_OPB_AWIDTH == 32) && (C_OPB_DWIDTH == 32) && ($bits(C_FAMILY) > 0));

    opb_slave_ack_fsm #(
        .C_BASEADDR (C_BASEADDR),
        .C_HIGHADDR (C_HIGHADDR)
    ) u_ackFsm (
        .clk       (OPB_Clk),
        .rst       (OPB_Rst),
        .i_abus    (w_abus),
        .i_select  (bus.OPB_select),
        .o_accept  (w_accept),
        .o_word    (w_word),
        .o_xferAck (w_xferAck)
    );

    // Side effects of a transfer land at the end of its ACK cycle.
    assign w_clrNew = w_xferAck && r_clrNewPend;
    assign w_clrOvr = w_xferAck && r_clrOvrPend;
    assign w_setOvr = user_valid && r_newFlag && !w_clrNew;

    // Read mux over the register state; out-of-range words read as zero.
    always_comb begin
        w_rdMux = '0;
        if (w_word == WORD_DATA) begin
            w_rdMux = r_data;
        end else if (w_word == WORD_STATUS) begin
            w_rdMux = packStatus(r_count, r_overrun, r_newFlag);
        end
    end

    // Register file, flag updates and registered read data.
    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            r_data       <= '0;
            r_count      <= '0;
            r_newFlag    <= 1'b0;
            r_overrun    <= 1'b0;
            r_dbus       <= '0;
            r_clrNewPend <= 1'b0;
            r_clrOvrPend <= 1'b0;
        end else begin
            r_dbus       <= w_accept ? w_rdMux : '0;
            r_clrNewPend <= w_accept && bus.OPB_RNW && (w_word == WORD_DATA);
            r_clrOvrPend <= w_accept && !bus.OPB_RNW && (w_word == WORD_STATUS)
                            && w_wdata[STAT_OVERRUN];

            if (user_valid) begin
                r_data    <= user_data_in;
                r_count   <= r_count + 16'd1;
                r_newFlag <= 1'b1;
            end else if (w_clrNew) begin
                r_newFlag <= 1'b0;
            end

            if (w_setOvr) begin
                r_overrun <= 1'b1;
            end else if (w_clrOvr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign bus.Sl_DBus    = r_dbus;
    assign bus.Sl_xferAck = w_xferAck;
    assign bus.Sl_errAck  = 1'b0;
    assign bus.Sl_retry   = 1'b0;
    assign bus.Sl_toutSup = 1'b0;

endmodule

// File: tb/tb_opb_register_simulink2ppc.sv
// Directed self-checking bench for the OPB Simulink-to-PPC register slave.
module tb_opb_register_simulink2ppc;

    logic        clk;
    logic        rst;
    logic [31:0] userData;
    logic        userValid;
    int          checks;
    int          errors;
    int          ackCount;

    opb_register_simulink2ppc_if bus ();

    opb_register_simulink2ppc dut (
        .OPB_Clk      (clk),
        .OPB_Rst      (rst),
        .user_data_in (userData),
        .user_valid   (userValid),
        .bus          (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic sel, input logic rnw,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        bus.OPB_select = sel;
        bus.OPB_RNW    = rnw;
        bus.OPB_ABus   = addr;
        bus.OPB_DBus   = wdata;
    endtask

    task automatic userPulse(input logic [31:0] data);
        userData  = data;
        userValid = 1'b1;
        tick();
        userValid = 1'b0;
    endtask

    task automatic doReset();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        userValid = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        checkOutput("rstAck", {31'd0, bus.Sl_xferAck}, 32'd0);
        checkOutput("rstData", bus.Sl_DBus, 32'd0);
        rst = 1'b0;
    endtask

    task automatic busRead(input string tag, input logic [31:0] addr,
                           input logic [31:0] expData);
        applyStimulus(1'b1, 1'b1, addr, 32'h0);
        tick();
        checkOutput({tag, "_ack"}, {31'd0, bus.Sl_xferAck}, 32'd1);
        checkOutput({tag, "_data"}, bus.Sl_DBus, expData);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        checkOutput({tag, "_ackDrop"}, {31'd0, bus.Sl_xferAck}, 32'd0);
        tick();
    endtask

    task automatic busWrite(input string tag, input logic [31:0] addr,
                            input logic [31:0] wdata);
        applyStimulus(1'b1, 1'b0, addr, wdata);
        tick();
        checkOutput({tag, "_ack"}, {31'd0, bus.Sl_xferAck}, 32'd1);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        checkOutput({tag, "_ackDrop"}, {31'd0, bus.Sl_xferAck}, 32'd0);
        tick();
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        userData  = '0;
        userValid = 1'b0;
        bus.OPB_BE      = 4'hF;
        bus.OPB_seqAddr = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);

        // Reset state and an empty STATUS read.
        doReset();
        checkOutput("tieOffs", {29'd0, bus.Sl_errAck, bus.Sl_retry, bus.Sl_toutSup}, 32'd0);
        busRead("statusAfterReset", 32'h01000F04, 32'h00000000);

        // Capture then read DATA; STATUS shows count 1 with new cleared.
        userPulse(32'hDEADBEEF);
        busRead("dataRead", 32'h01000F00, 32'hDEADBEEF);
        busRead("statusAfterData", 32'h01000F04, 32'h00010000);

        // Two captures without a read produce an overrun; write clears it.
        doReset();
        userPulse(32'hA5A5A5A5);
        userPulse(32'h5A5A5A5A);
        busRead("statusOverrun", 32'h01000F04, 32'h00020003);
        busWrite("clearOverrun", 32'h01000F04, 32'h00000002);
        busRead("statusCleared", 32'h01000F04, 32'h00020001);
        busWrite("dataWriteIgnored", 32'h01000F00, 32'h12345678);
        busRead("dataUnchanged", 32'h01000F00, 32'h5A5A5A5A);
        busRead("word2Zero", 32'h01000F08, 32'h00000000);
        busRead("topWordZero", 32'h01000FFC, 32'h00000000);

        // Address just past the window is never acknowledged.
        applyStimulus(1'b1, 1'b1, 32'h01001000, 32'h0);
        tick();
        checkOutput("outOfWindow1", {31'd0, bus.Sl_xferAck}, 32'd0);
        tick();
        checkOutput("outOfWindow2", {31'd0, bus.Sl_xferAck}, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        tick();

        // Capture coincident with a DATA ack: old data returned, new stays set.
        doReset();
        userPulse(32'h22222222);
        applyStimulus(1'b1, 1'b1, 32'h01000F00, 32'h0);
        tick();
        userData  = 32'h11111111;
        userValid = 1'b1;
        checkOutput("coincAck", {31'd0, bus.Sl_xferAck}, 32'd1);
        checkOutput("coincData", bus.Sl_DBus, 32'h22222222);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        userValid = 1'b0;
        tick();
        busRead("coincStatus", 32'h01000F04, 32'h00020001);

        // Overrun set coincident with an overrun-clear write: set wins.
        applyStimulus(1'b1, 1'b0, 32'h01000F04, 32'h00000002);
        tick();
        userData  = 32'h33333333;
        userValid = 1'b1;
        checkOutput("setWinsAck", {31'd0, bus.Sl_xferAck}, 32'd1);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        userValid = 1'b0;
        tick();
        busRead("setWinsStatus", 32'h01000F04, 32'h00030003);
        busRead("setWinsData", 32'h01000F00, 32'h33333333);

        // Select held for five cycles yields exactly one ack pulse.
        ackCount = 0;
        applyStimulus(1'b1, 1'b1, 32'h01000F04, 32'h0);
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.Sl_xferAck) ackCount++;
            if (i == 0) checkOutput("heldData", bus.Sl_DBus, 32'h00030002);
        end
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        if (bus.Sl_xferAck) ackCount++;
        tick();
        checkOutput("heldAckCount", ackCount, 32'd1);

        // Update count wraps from 0xFFFF to 0x0000.
        doReset();
        userData  = 32'h0BADF00D;
        userValid = 1'b1;
        repeat (65535) tick();
        userValid = 1'b0;
        busRead("countFFFF", 32'h01000F04, 32'hFFFF0003);
        userPulse(32'hCAFEF00D);
        busRead("countWrap", 32'h01000F04, 32'h00000003);

        // Reset in the ACK cycle aborts; a coincident capture is discarded.
        userPulse(32'hABCD0123);
        applyStimulus(1'b1, 1'b1, 32'h01000F00, 32'h0);
        tick();
        checkOutput("abortAckBefore", {31'd0, bus.Sl_xferAck}, 32'd1);
        rst       = 1'b1;
        userData  = 32'h77777777;
        userValid = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        checkOutput("abortAck", {31'd0, bus.Sl_xferAck}, 32'd0);
        checkOutput("abortData", bus.Sl_DBus, 32'd0);
        rst       = 1'b0;
        userValid = 1'b0;
        tick();
        busRead("abortStatus", 32'h01000F04, 32'h00000000);
        busRead("abortDataReg", 32'h01000F00, 32'h00000000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/opb_register_simulink2ppc.md
OPB_REGISTER_SIMULINK2PPC -- requirements
Module: opb_register_simulink2ppc

Interface
REQ-001 SHALL have parameter C_BASEADDR, default 32'h01000F00, base of the decoded window.
REQ-002 SHALL have parameter C_HIGHADDR, default 32'h01000FFF, top of the decoded window.
REQ-003 SHALL have parameters C_OPB_AWIDTH = 32, C_OPB_DWIDTH = 32 and C_FAMILY = "virtex5"; these are informational only.
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 OPB_Clk, input, 1: the only clock; all logic on its rising edge.
REQ-006 OPB_Rst, input, 1: synchronous active-high reset.
REQ-007 OPB_ABus, input, [0:31]: byte address.
REQ-008 OPB_BE, input, [0:3]: byte enables, ignored.
REQ-009 OPB_DBus, input, [0:31]: write data.
REQ-010 OPB_RNW, input, 1: 1 = read, 0 = write.
REQ-011 OPB_select, input, 1: transfer in progress.
REQ-012 OPB_seqAddr, input, 1: ignored.
REQ-013 Sl_DBus, output, [0:31]: read data; all-zero unless Sl_xferAck = 1.
REQ-014 Sl_xferAck, output, 1: single-cycle transfer acknowledge.
REQ-015 Sl_errAck, Sl_retry and Sl_toutSup, outputs, 1 each: tied to 0.
REQ-016 user_data_in, input, [31:0]: value from user logic.
REQ-017 user_valid, input, 1: single-cycle strobe that captures user_data_in.

Function
REQ-018 Bit numbering: OPB bit 0 = user bit 31.
- Register DATA (word 0, offset 0x0) SHALL hold the last captured user_data_in.
- Register STATUS (word 1, offset 0x4) SHALL carry: [0] new, [1] overrun, [15:2] zero, [31:16] update_count.
REQ-019 Decode: hit = OPB_select AND C_BASEADDR <= OPB_ABus <= C_HIGHADDR.
- Word index = (OPB_ABus - C_BASEADDR) >> 2.
- Word indices 2 and above SHALL read as zero and ignore writes, but are still acknowledged.
REQ-020 Ack FSM states:
- IDLE -> ACK on hit.
- ACK -> WAIT unconditionally.
- WAIT -> IDLE when OPB_select = 0.
- Sl_xferAck = 1 only in ACK.
REQ-021 Latency: a hit sampled at edge N SHALL give Sl_xferAck = 1 and valid Sl_DBus in cycle N+1, for exactly one cycle.
REQ-022 Read data SHALL be registered and taken from register state as of edge N.
REQ-023 On user_valid:
- DATA <= user_data_in.
- update_count <= update_count + 1, 16-bit and wrapping (0xFFFF -> 0x0000).
- new <= 1.
- overrun <= 1 if new was already 1 and new is not being cleared in the same cycle.
REQ-024 An acknowledged read of DATA SHALL clear new in the ACK cycle.
REQ-025 An acknowledged write to STATUS with OPB_DBus user bit 1 = 1 SHALL clear overrun; all other write bits are ignored, and writes to DATA are ignored.
REQ-026 Simultaneous user_valid and a DATA-read ACK:
- The read returns the old DATA.
- new ends at 1.
- overrun is unchanged.
REQ-027 Simultaneous user_valid that would set overrun and an overrun-clear write: the set SHALL win, so overrun = 1.
REQ-028 A hit while the FSM is in WAIT SHALL not re-acknowledge; only the rising edge of a transfer is acked.

Reset
REQ-029 While OPB_Rst = 1:
- DATA, update_count, new, overrun = 0.
- FSM = IDLE.
- Sl_xferAck = 0 and Sl_DBus = 0.
REQ-030 Reset asserted during ACK or WAIT SHALL abort the transfer with no ack in the following cycle.
REQ-031 A user_valid coincident with reset SHALL be discarded.

Structure
REQ-032 Package opb_s2p_pkg SHALL hold:
- the word-index constants (DATA = 0, STATUS = 1);
- the STATUS bit positions;
- the ack FSM state type.
REQ-033 Sub-module opb_slave_ack_fsm SHALL implement the decode and REQ-020/021/028; the top module holds the registers and read mux.

Verification
REQ-034 Reset, then read 0x01000F04 -> one ack one cycle after select; Sl_DBus = 0x00000000.
REQ-035 user_valid with 0xDEADBEEF, then read 0x01000F00 -> 0xDEADBEEF; the next STATUS read = 0x00010000 (count 1, new cleared).
REQ-036 Two user_valid pulses with no read -> STATUS = 0x00020003; write 0x00000002 to 0x01000F04 -> STATUS = 0x00020001.
REQ-037 user_valid 0x11111111 in the same cycle as a DATA ACK whose prior DATA = 0x22222222 -> read returns 0x22222222; new = 1; overrun = 0.
REQ-038 65536 user_valid pulses -> update_count wraps to 0x0000; select held 5 cycles -> exactly one ack pulse.
REQ-039 Reset asserted in the ACK cycle -> Sl_xferAck = 0 on the next edge; FSM = IDLE; all registers = 0.
